// File: rtl/alu_divider8_if.sv
// Start/done handshake and result bundle shared by the divider and whatever drives it.
// The master side issues operands and start; the slave side returns results and status.
interface alu_divider8_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             OF;
    logic             zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero, OF, zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_zero, OF, zero
    );
endinterface

// File: rtl/alu_divider8.sv
// Multi-cycle signed divider: restoring division on magnitudes, one quotient bit per clock,
// then a single sign-fix cycle. Quotient truncates toward zero; remainder follows the dividend.
module alu_divider8 #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_divider8_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] divisor_mag;
    logic             sign_q;
    logic             sign_r;
    logic             ovf_case;
    logic             dz_pend;

    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             ovf_detect;

    // shift_reg starts as the dividend magnitude and fills with quotient bits from the right,
    // so after WIDTH steps it holds the quotient magnitude and part_rem the remainder magnitude.
    always_comb begin
        dividend_abs = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        divisor_abs  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        shifted      = {part_rem[WIDTH-1:0], shift_reg[WIDTH-1]};
        trial        = shifted - {1'b0, divisor_mag};
        q_fix        = sign_q ? -shift_reg : shift_reg;
        r_fix        = sign_r ? -part_rem[WIDTH-1:0] : part_rem[WIDTH-1:0];
        ovf_detect   = (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.divisor);
    end

    // A zero divisor is answered directly from IDLE; dz_pend delays its done pulse by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            part_rem      <= '0;
            shift_reg     <= '0;
            divisor_mag   <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            ovf_case      <= 1'b0;
            dz_pend       <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.div_zero  <= 1'b0;
            bus.OF        <= 1'b0;
            bus.zero      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dz_pend) begin
                        bus.done <= 1'b1;
                        dz_pend  <= 1'b0;
                    end else if (bus.start) begin
                        sign_q      <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        sign_r      <= bus.dividend[WIDTH-1];
                        ovf_case    <= ovf_detect;
                        shift_reg   <= dividend_abs;
                        divisor_mag <= divisor_abs;
                        part_rem    <= '0;
                        count       <= '0;
                        if (bus.divisor == '0) begin
                            bus.quotient  <= '1;
                            bus.remainder <= bus.dividend;
                            bus.div_zero  <= 1'b1;
                            bus.OF        <= 1'b0;
                            bus.zero      <= 1'b0;
                            dz_pend       <= 1'b1;
                        end else begin
                            bus.busy <= 1'b1;
                            state    <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (!trial[WIDTH]) begin
                        part_rem  <= trial;
                        shift_reg <= {shift_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        part_rem  <= shifted;
                        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    bus.quotient  <= q_fix;
                    bus.remainder <= r_fix;
                    bus.OF        <= ovf_case;
                    bus.zero      <= (q_fix == '0);
                    bus.div_zero  <= 1'b0;
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_divider8.sv
// Scoreboard bench for alu_divider8: stimulus pushes model results, a negedge monitor pops
// and compares them (including done timing) whenever the divider pulses done.
module tb_alu_divider8;
    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       of;
        logic       zr;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    alu_divider8_if #(.WIDTH(8)) bus ();

    alu_divider8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain signed integer arithmetic, with the two special cases handled explicitly.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int due);
        exp_t e;
        int   ai, bi, qi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        e.due = due;
        e.of  = 1'b0;
        e.dz  = 1'b0;
        if (bi == 0) begin
            e.q  = 8'hFF;
            e.r  = a;
            e.dz = 1'b1;
            e.zr = 1'b0;
        end else if (ai == -128 && bi == -1) begin
            e.q  = 8'h80;
            e.r  = 8'h00;
            e.of = 1'b1;
            e.zr = 1'b0;
        end else begin
            qi   = ai / bi;
            ri   = ai % bi;
            e.q  = qi[7:0];
            e.r  = ri[7:0];
            e.zr = (e.q == 8'h00);
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; the next rising edge samples start.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit accepted);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        if (accepted) sb.push_back(model(a, b, cyc + 1 + ((b == 8'h00) ? 1 : 9)));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_idle: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("latency", 32'(cyc), 32'(e.due));
                    checkOutput("quotient", 32'(bus.quotient), 32'(e.q));
                    checkOutput("remainder", 32'(bus.remainder), 32'(e.r));
                    checkOutput("div_zero", 32'(bus.div_zero), 32'(e.dz));
                    checkOutput("OF", 32'(bus.OF), 32'(e.of));
                    checkOutput("zero", 32'(bus.zero), 32'(e.zr));
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL missed_done: got no done by cycle %0d, expected at %0d", cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nb;
        int nd;
        logic [7:0] a, b;
        bus.start    = 1'b0;
        bus.dividend = 8'h00;
        bus.divisor  = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rst_quotient", 32'(bus.quotient), 32'h0);
        checkOutput("rst_remainder", 32'(bus.remainder), 32'h0);
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_done", 32'(bus.done), 32'h0);
        checkOutput("rst_flags", {29'b0, bus.div_zero, bus.OF, bus.zero}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic 100/7 with busy length");
        applyStimulus(8'h64, 8'h07, 1'b1);
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.busy) nb++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", 32'(nb), 32'd9);
        waitIdle();

        $display("[TB] sign combinations and boundaries");
        applyStimulus(8'h9C, 8'h07, 1'b1); waitIdle();
        applyStimulus(8'h64, 8'hF9, 1'b1); waitIdle();
        applyStimulus(8'h9C, 8'hF9, 1'b1); waitIdle();
        applyStimulus(8'h03, 8'h05, 1'b1); waitIdle();
        applyStimulus(8'h80, 8'hFF, 1'b1); waitIdle();
        applyStimulus(8'h80, 8'h01, 1'b1); waitIdle();

        $display("[TB] divide by zero");
        applyStimulus(8'h05, 8'h00, 1'b1);
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.busy) nb++;
            @(negedge clk);
        end
        checkOutput("dz_busy_cycles", 32'(nb), 32'd0);
        waitIdle();
        applyStimulus(8'h09, 8'h03, 1'b1); waitIdle();

        $display("[TB] start while busy is ignored");
        applyStimulus(8'h64, 8'h07, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(8'h11, 8'h02, 1'b0);
        waitIdle();

        $display("[TB] back-to-back and output holding");
        applyStimulus(8'h64, 8'h07, 1'b1);
        repeat (sb[0].due - cyc) @(negedge clk);
        applyStimulus(8'h9C, 8'h07, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("hold_quotient", 32'(bus.quotient), 32'h0E);
        checkOutput("hold_remainder", 32'(bus.remainder), 32'h02);
        checkOutput("hold_busy", 32'(bus.busy), 32'h1);
        waitIdle();

        $display("[TB] reset during iteration");
        applyStimulus(8'h64, 8'h07, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("abort_quotient", 32'(bus.quotient), 32'h0);
        checkOutput("abort_remainder", 32'(bus.remainder), 32'h0);
        checkOutput("abort_busy", 32'(bus.busy), 32'h0);
        checkOutput("abort_flags", {28'b0, bus.done, bus.div_zero, bus.OF, bus.zero}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        checkOutput("abort_no_done", 32'(nd), 32'd0);
        applyStimulus(8'h7F, 8'h02, 1'b1); waitIdle();

        $display("[TB] randomized operands");
        for (int n = 0; n < 60; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) b = 8'h00;
            if ($urandom_range(0, 9) == 0) begin
                a = 8'h80;
                b = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h01;
            end
            if (sb.size() > 0 && sb[$].due > cyc) repeat (sb[$].due - cyc) @(negedge clk);
            applyStimulus(a, b, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) waitIdle();
        end
        waitIdle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
